// File: rtl/vga_capture_ctrl.sv
// VGA frame capture controller.
// Measures the active raster size of one frame, then captures num_frames
// whole frames. Each captured frame is bracketed by go pulses, and done is
// pulsed at the end of the run.
module vga_capture_ctrl #(
    parameter int DIM_W = 16
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             hblnk,
    input  logic             vblnk,
    input  logic             arm,
    input  logic [7:0]       num_frames,
    output logic             go,
    output logic             pix_valid,
    output logic [DIM_W-1:0] xdim,
    output logic [DIM_W-1:0] ydim,
    output logic             dims_valid,
    output logic             busy,
    output logic [7:0]       frame_cnt,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, SYNC, MEASURE, WAIT_SOF, CAPTURE} state_t;

    localparam logic [DIM_W-1:0] DIM_MAX = '1;

    state_t     state;
    logic       hblnk_q;
    logic       vblnk_q;
    logic [7:0] nf_q;
    logic       x_done;

    logic       sof;
    logic       eof;
    logic       eol;
    logic       active;
    logic [8:0] frame_nxt;

    assign sof       = vblnk_q & ~vblnk;
    assign eof       = ~vblnk_q & vblnk;
    assign eol       = ~hblnk_q & hblnk & ~vblnk;
    assign active    = ~hblnk & ~vblnk;
    assign frame_nxt = {1'b0, frame_cnt} + 9'd1;

    // Previous-cycle blanking levels used for edge detection.
    always_ff @(posedge pclk) begin
        hblnk_q <= hblnk;
        vblnk_q <= vblnk;
    end

    // Capture FSM with all outputs registered alongside the state.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= IDLE;
            go         <= 1'b0;
            pix_valid  <= 1'b0;
            xdim       <= '0;
            ydim       <= '0;
            dims_valid <= 1'b0;
            busy       <= 1'b0;
            frame_cnt  <= '0;
            done       <= 1'b0;
            nf_q       <= '0;
            x_done     <= 1'b0;
        end else begin
            go        <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm && num_frames != 8'd0) begin
                        nf_q       <= num_frames;
                        frame_cnt  <= '0;
                        dims_valid <= 1'b0;
                        xdim       <= '0;
                        ydim       <= '0;
                        state      <= SYNC;
                        busy       <= 1'b1;
                    end
                end
                SYNC: begin
                    // The SOF cycle already belongs to the measured frame,
                    // so its pixel and any line end are counted here.
                    if (sof) begin
                        state  <= MEASURE;
                        xdim   <= {{(DIM_W-1){1'b0}}, active};
                        ydim   <= {{(DIM_W-1){1'b0}}, eol};
                        x_done <= eol;
                    end
                end
                MEASURE: begin
                    if (eof) begin
                        state      <= WAIT_SOF;
                        dims_valid <= 1'b1;
                    end else begin
                        if (active && !x_done && xdim != DIM_MAX)
                            xdim <= xdim + 1'b1;
                        if (eol) begin
                            x_done <= 1'b1;
                            if (ydim != DIM_MAX)
                                ydim <= ydim + 1'b1;
                        end
                    end
                end
                WAIT_SOF: begin
                    if (sof) begin
                        go        <= 1'b1;
                        pix_valid <= active;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    pix_valid <= active;
                    if (eof) begin
                        frame_cnt <= frame_nxt[7:0];
                        if (frame_nxt < {1'b0, nf_q}) begin
                            state <= WAIT_SOF;
                        end else begin
                            go    <= 1'b1;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_capture_ctrl.sv
// Directed bench for vga_capture_ctrl on a small 8x4 raster
// (12-cycle lines, 6-line frames).
module tb_vga_capture_ctrl;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        hblnk = 1'b1;
    logic        vblnk = 1'b1;
    logic        arm = 1'b0;
    logic [7:0]  num_frames = 8'd0;
    logic        go;
    logic        pix_valid;
    logic [15:0] xdim;
    logic [15:0] ydim;
    logic        dims_valid;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        done;

    int checks = 0;
    int errors = 0;

    int h = 0;
    int v = 4;
    int frame_no = 0;
    bit hold_low = 1'b0;

    int go_cnt = 0;
    int pix_cnt = 0;
    int done_cnt = 0;
    int first_go_frame = -1;

    vga_capture_ctrl #(.DIM_W(16)) dut (
        .pclk(pclk), .rst(rst), .hblnk(hblnk), .vblnk(vblnk), .arm(arm),
        .num_frames(num_frames), .go(go), .pix_valid(pix_valid), .xdim(xdim),
        .ydim(ydim), .dims_valid(dims_valid), .busy(busy),
        .frame_cnt(frame_cnt), .done(done)
    );

    always #5 pclk = ~pclk;

    // Raster generator: 8 active + 4 hblank pixels; 4 active + 2 vblank lines.
    always @(negedge pclk) begin
        if (hold_low) begin
            hblnk = 1'b0;
            vblnk = 1'b0;
        end else begin
            h++;
            if (h == 12) begin
                h = 0;
                v++;
                if (v == 6) begin
                    v = 0;
                    frame_no++;
                end
            end
            hblnk = (h >= 8);
            vblnk = (v >= 4);
        end
    end

    // Event counters sampled just after each active edge.
    always @(posedge pclk) begin
        #1;
        if (go === 1'b1) begin
            go_cnt++;
            if (first_go_frame < 0) first_go_frame = frame_no;
        end
        if (pix_valid === 1'b1) pix_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        go_cnt = 0;
        pix_cnt = 0;
        done_cnt = 0;
        first_go_frame = -1;
    endtask

    task automatic do_arm(input logic [7:0] n);
        @(negedge pclk);
        arm = 1'b1;
        num_frames = n;
        @(negedge pclk);
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            #2;
            if (done_cnt != d0) break;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic wait_go(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            #2;
            if (go_cnt >= target) break;
        end
        chk({tag, "_go_seen"}, 32'(go_cnt >= target), 32'd1);
    endtask

    task automatic wait_line(input int vl, input int hl, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            #1;
            if (v == vl && h == hl) break;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_go"}, 32'(go), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_xdim"}, 32'(xdim), 32'd0);
        chk({tag, "_ydim"}, 32'(ydim), 32'd0);
        chk({tag, "_dims_valid"}, 32'(dims_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;

        // Reset state.
        repeat (4) @(negedge pclk);
        chk_reset_vals("rst");
        rst = 1'b0;

        // Basic two-frame run.
        clr();
        do_arm(8'd2);
        chk("basic_busy_armed", 32'(busy), 32'd1);
        wait_done("basic", 1000);
        chk("basic_xdim", 32'(xdim), 32'd8);
        chk("basic_ydim", 32'(ydim), 32'd4);
        chk("basic_dims_valid", 32'(dims_valid), 32'd1);
        chk("basic_go_cnt", go_cnt, 32'd3);
        chk("basic_pix_cnt", pix_cnt, 32'd64);
        chk("basic_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("basic_done_cnt", done_cnt, 32'd1);
        chk("basic_busy_end", 32'(busy), 32'd0);
        repeat (100) @(negedge pclk);
        chk("hold_xdim", 32'(xdim), 32'd8);
        chk("hold_ydim", 32'(ydim), 32'd4);
        chk("hold_dims_valid", 32'(dims_valid), 32'd1);
        chk("hold_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("hold_go_cnt", go_cnt, 32'd3);

        // Arm in the middle of an active frame: that frame is skipped.
        begin
            int arm_frame;
            clr();
            wait_line(1, 3, 200);
            arm_frame = frame_no;
            do_arm(8'd1);
            wait_done("mid", 1000);
            chk("mid_first_go_frame", first_go_frame, 32'(arm_frame + 2));
            chk("mid_xdim", 32'(xdim), 32'd8);
            chk("mid_ydim", 32'(ydim), 32'd4);
            chk("mid_go_cnt", go_cnt, 32'd2);
            chk("mid_pix_cnt", pix_cnt, 32'd32);
        end

        // Ignored arms: zero frames in IDLE, and any arm during CAPTURE.
        clr();
        do_arm(8'd0);
        repeat (200) @(negedge pclk);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_go_cnt", go_cnt, 32'd0);
        chk("zero_frame_cnt", 32'(frame_cnt), 32'd1);
        do_arm(8'd2);
        wait_go("recap", 1, 1000);
        repeat (5) @(negedge pclk);
        do_arm(8'd5);
        chk("recap_busy", 32'(busy), 32'd1);
        wait_done("recap", 1000);
        chk("recap_go_cnt", go_cnt, 32'd3);
        chk("recap_frame_cnt", 32'(frame_cnt), 32'd2);
        repeat (300) @(negedge pclk);
        chk("recap_busy_after", 32'(busy), 32'd0);
        chk("recap_go_after", go_cnt, 32'd3);

        // Reset during the second captured frame of a three-frame run.
        clr();
        do_arm(8'd3);
        wait_go("midrst", 2, 1500);
        repeat (10) @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        clr();
        repeat (400) @(negedge pclk);
        chk("midrst_no_go", go_cnt, 32'd0);
        chk("midrst_no_done", done_cnt, 32'd0);
        do_arm(8'd1);
        wait_done("postrst", 1000);
        chk("postrst_go_cnt", go_cnt, 32'd2);
        chk("postrst_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("postrst_xdim", 32'(xdim), 32'd8);

        // Width counter saturation with hblnk held low in the measured frame.
        clr();
        wait_line(4, 0, 200);
        do_arm(8'd1);
        wait_line(0, 2, 200);
        hold_low = 1'b1;
        repeat (70000) @(negedge pclk);
        #1;
        chk("sat_xdim_hold", 32'(xdim), 32'hFFFF);
        hold_low = 1'b0;
        wait_done("sat", 1000);
        chk("sat_xdim", 32'(xdim), 32'hFFFF);
        chk("sat_ydim", 32'(ydim), 32'd4);

        // Random run lengths: N frames give N+1 go pulses.
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(1, 5);
            clr();
            do_arm(8'(n));
            wait_done("rnd", 2000);
            chk("rnd_go_cnt", go_cnt, 32'(n + 1));
            chk("rnd_frame_cnt", 32'(frame_cnt), 32'(n));
            chk("rnd_pix_cnt", pix_cnt, 32'(32 * n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
